timer_dev: RTL



---
 rtl/timer_dev.sv | 130 +++++++++++++
 1 files changed

// File: rtl/timer_dev.sv
// Memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes.
// Raises irq when the count expires; software acknowledges by writing CTRL or PRESET.
module timer_dev (
    input  logic        clk,
    input  logic        clr,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    localparam logic [1:0] MODE_AUTO = 2'b01;

    logic [1:0]  state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        set_pend;
    logic        clr_pend_fsm;

    assign wr_ctrl   = we && (addr == A_CTRL);
    assign wr_preset = we && (addr == A_PRESET);

    always_comb begin
        state_d      = state_q;
        en_d         = en_q;
        mode_d       = mode_q;
        im_d         = im_q;
        preset_d     = preset_q;
        count_d      = count_q;
        set_pend     = 1'b0;
        clr_pend_fsm = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                // Zero check comes before the decrement, so COUNT never wraps.
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (count_q == 32'd0) begin
                    set_pend = 1'b1;
                    state_d  = ST_INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            ST_INT: begin
                if (mode_q == MODE_AUTO) begin
                    clr_pend_fsm = 1'b1;
                    state_d      = ST_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Software writes land after the FSM so a written EN beats the INT-state clear.
        if (wr_ctrl) begin
            en_d   = din[0];
            mode_d = din[2:1];
            im_d   = din[3];
        end
        if (wr_preset) preset_d = din;

        // An expiry on the same edge as an acknowledge must not be lost.
        if (set_pend)
            pending_d = 1'b1;
        else if (wr_ctrl || wr_preset || clr_pend_fsm)
            pending_d = 1'b0;
        else
            pending_d = pending_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            mode_q    <= 2'b00;
            im_q      <= 1'b0;
            preset_q  <= 32'd0;
            count_q   <= 32'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            im_q      <= im_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            A_CTRL:   dout = {28'd0, im_q, mode_q, en_q};
            A_PRESET: dout = preset_q;
            A_COUNT:  dout = count_q;
            default:  dout = 32'd0;
        endcase
    end

    assign irq = im_q & pending_q;

endmodule
